// File: rtl/sorted_16_serializer_pkg.sv
// Shared sizing constants and helpers for the sorted-vector serializer.
package sorted_16_serializer_pkg;

  localparam int unsigned N_ELEM = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] N_SLOTS  = CNT_W'(2);

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/sorted_16_slot.sv
// One buffered vector (data + labels) with a write enable and an indexed read port.
module sorted_16_slot
  import sorted_16_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LABEL_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [DATA_WIDTH*N_ELEM-1:0]  x,
  input  logic [LABEL_WIDTH*N_ELEM-1:0] x_label,
  input  logic [IDX_W-1:0]              idx,
  output logic [DATA_WIDTH-1:0]         data,
  output logic [LABEL_WIDTH-1:0]        label
);

  logic [DATA_WIDTH-1:0]  data_q  [N_ELEM];
  logic [LABEL_WIDTH-1:0] label_q [N_ELEM];

  // Capture the whole vector on a write, unpacking elements into the register array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_ELEM); i++) begin
        data_q[i]  <= '0;
        label_q[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < int'(N_ELEM); i++) begin
        data_q[i]  <= x[DATA_WIDTH*i +: DATA_WIDTH];
        label_q[i] <= x_label[LABEL_WIDTH*i +: LABEL_WIDTH];
      end
    end
  end

  assign data  = data_q[idx];
  assign label = label_q[idx];

endmodule

// File: rtl/sorted_16_serializer.sv
// Ping-pong buffers sorted 16-element vectors and streams them one element per handshake.
module sorted_16_serializer
  import sorted_16_serializer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LABEL_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          x_valid,
  input  logic [DATA_WIDTH*N_ELEM-1:0]  x,
  input  logic [LABEL_WIDTH*N_ELEM-1:0] x_label,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [LABEL_WIDTH-1:0]        m_label,
  output logic [IDX_W-1:0]              m_index,
  output logic                          m_first,
  output logic                          m_last,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt
);

  logic [CNT_W-1:0] count;
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] idx;

  logic pop_c, free_c, cap_c, drop_c;
  logic [1:0] we_c;

  logic [DATA_WIDTH-1:0]  slot_data  [2];
  logic [LABEL_WIDTH-1:0] slot_label [2];

  // Handshake decode; a slot freed by the final pop can be refilled in the same cycle.
  assign pop_c  = m_valid & m_ready;
  assign free_c = pop_c & (idx == LAST_IDX);
  assign cap_c  = x_valid & ((count < N_SLOTS) | free_c);
  assign drop_c = x_valid & ~cap_c;
  assign we_c   = {cap_c & wr_sel, cap_c & ~wr_sel};

  // Two vector slots, written alternately and read through the current element index.
  for (genvar s = 0; s < 2; s++) begin : g_slot
    sorted_16_slot #(
      .DATA_WIDTH  (DATA_WIDTH),
      .LABEL_WIDTH (LABEL_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .we      (we_c[s]),
      .x       (x),
      .x_label (x_label),
      .idx     (idx),
      .data    (slot_data[s]),
      .label   (slot_label[s])
    );
  end

  // Occupancy, slot pointers, element index and drop bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      idx      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      count <= count + CNT_W'(cap_c) - CNT_W'(free_c);
      if (cap_c) begin
        wr_sel <= ~wr_sel;
      end
      if (pop_c) begin
        if (free_c) begin
          idx    <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop_c) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign m_valid = (count != '0);
  assign m_data  = rd_sel ? slot_data[1]  : slot_data[0];
  assign m_label = rd_sel ? slot_label[1] : slot_label[0];
  assign m_index = idx;
  assign m_first = (idx == '0);
  assign m_last  = (idx == LAST_IDX);

endmodule

// File: tb/tb_sorted_16_serializer.sv
// Directed self-checking bench for the sorted 16-element serializer.
module tb_sorted_16_serializer;

  localparam int DW = 8;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            x_valid;
  logic [DW*16-1:0] x;
  logic [LW*16-1:0] x_label;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [LW-1:0]   m_label;
  logic [3:0]      m_index;
  logic            m_first;
  logic            m_last;
  logic            ovf_clr;
  logic            overflow;
  logic [7:0]      drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sorted_16_serializer #(.DATA_WIDTH(DW), .LABEL_WIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .x_label  (x_label),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_label  (m_label),
    .m_index  (m_index),
    .m_first  (m_first),
    .m_last   (m_last),
    .ovf_clr  (ovf_clr),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Element i = base+i, label i = lbase+i (both wrap to their widths).
  function automatic logic [DW*16-1:0] mk_x(input int base);
    logic [DW*16-1:0] v;
    for (int i = 0; i < 16; i++) v[DW*i +: DW] = DW'(base + i);
    return v;
  endfunction

  function automatic logic [LW*16-1:0] mk_l(input int lbase);
    logic [LW*16-1:0] v;
    for (int i = 0; i < 16; i++) v[LW*i +: LW] = LW'(lbase + i);
    return v;
  endfunction

  // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    x_valid = 1'b0; x = '0; x_label = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    do_reset();
    n_tests++;
    if ({m_valid, m_data, m_label, m_index, m_first, m_last, overflow, drop_cnt} !==
        {1'b0, 8'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%0d l=%0d i=%0d f=%b la=%b ovf=%b dc=%0d, want v=0 d=0 l=0 i=0 f=1 la=0 ovf=0 dc=0",
               m_valid, m_data, m_label, m_index, m_first, m_last, overflow, drop_cnt);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    x = mk_x(10); x_label = mk_l(0); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({m_valid, m_data, m_label, m_index, m_first, m_last} !==
          {1'b1, 8'(10 + k), 4'(k), 4'(k), 1'(k == 0), 1'(k == 15)}) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got v=%b d=%0d l=%0d i=%0d f=%b la=%b, want v=1 d=%0d l=%0d i=%0d f=%b la=%b",
                 k, m_valid, m_data, m_label, m_index, m_first, m_last,
                 10 + k, k, k, k == 0, k == 15);
      end
      tick();
    end
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    x = mk_x(10); x_label = mk_l(0); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      n_tests++;
      if ({m_valid, m_data, m_label, m_index} !== {1'b1, 8'(10 + c / 2), 4'(c / 2), 4'(c / 2)}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got v=%b d=%0d l=%0d i=%0d, want v=1 d=%0d l=%0d i=%0d",
                 c, m_valid, m_data, m_label, m_index, 10 + c / 2, c / 2, c / 2);
      end
      m_ready = (c % 2 == 1);
      tick();
    end
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: m_valid got %b want 0", m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int base [2];
    int lb   [2];
    base = '{20, 60}; lb = '{3, 9};
    m_ready = 1'b0;
    x_valid = 1'b1;
    x = mk_x(20);  x_label = mk_l(3);  tick();
    x = mk_x(60);  x_label = mk_l(9);  tick();
    x = mk_x(200); x_label = mk_l(12); tick();
    x_valid = 1'b0;
    n_tests++;
    if ({m_valid, overflow, drop_cnt} !== {1'b1, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ovf_third_drop: got v=%b ovf=%b dc=%0d, want v=1 ovf=1 dc=1",
               m_valid, overflow, drop_cnt);
    end
    m_ready = 1'b1;
    for (int b = 0; b < 32; b++) begin
      n_tests++;
      if ({m_valid, m_data, m_label, m_index} !==
          {1'b1, 8'(base[b / 16] + b % 16), 4'(lb[b / 16] + b % 16), 4'(b % 16)}) begin
        n_fail++;
        $display("FAIL ovf_drain_beat%0d: got v=%b d=%0d l=%0d i=%0d, want v=1 d=%0d l=%0d i=%0d",
                 b, m_valid, m_data, m_label, m_index,
                 base[b / 16] + b % 16, (lb[b / 16] + b % 16) % 16, b % 16);
      end
      tick();
    end
    n_tests++;
    if ({m_valid, overflow, drop_cnt} !== {1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ovf_after_drain: got v=%b ovf=%b dc=%0d, want v=0 ovf=1 dc=1",
               m_valid, overflow, drop_cnt);
    end
    m_ready = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++;
    if ({overflow, drop_cnt} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b dc=%0d, want ovf=0 dc=0", overflow, drop_cnt);
    end
  endtask

  task automatic test_reuse_freed_slot();
    int base [3];
    base = '{30, 90, 150};
    m_ready = 1'b0;
    x_valid = 1'b1;
    x = mk_x(30); x_label = mk_l(1); tick();
    x = mk_x(90); x_label = mk_l(5); tick();
    x_valid = 1'b0;
    m_ready = 1'b1;
    for (int b = 0; b < 48; b++) begin
      n_tests++;
      if ({m_valid, m_data, m_index} !== {1'b1, 8'(base[b / 16] + b % 16), 4'(b % 16)}) begin
        n_fail++;
        $display("FAIL reuse_beat%0d: got v=%b d=%0d i=%0d, want v=1 d=%0d i=%0d",
                 b, m_valid, m_data, m_index, base[b / 16] + b % 16, b % 16);
      end
      if (b == 15) begin
        x = mk_x(150); x_label = mk_l(7); x_valid = 1'b1;
      end
      tick();
      x_valid = 1'b0;
    end
    n_tests++;
    if ({m_valid, overflow, drop_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reuse_no_drop: got v=%b ovf=%b dc=%0d, want v=0 ovf=0 dc=0",
               m_valid, overflow, drop_cnt);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_drop_saturate();
    m_ready = 1'b0;
    x = mk_x(40); x_label = mk_l(2); x_valid = 1'b1;
    tick();
    tick();
    for (int d = 1; d <= 260; d++) begin
      tick();
      if (d == 254 || d == 255 || d == 260) begin
        n_tests++;
        if ({overflow, drop_cnt} !== {1'b1, 8'(d > 255 ? 255 : d)}) begin
          n_fail++;
          $display("FAIL drop_count_after%0d: got ovf=%b dc=%0d, want ovf=1 dc=%0d",
                   d, overflow, drop_cnt, d > 255 ? 255 : d);
        end
      end
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    x_valid = 1'b0;
    n_tests++;
    if ({overflow, drop_cnt, m_valid, m_data} !== {1'b0, 8'd0, 1'b1, 8'd40}) begin
      n_fail++;
      $display("FAIL drop_clr_priority: got ovf=%b dc=%0d v=%b d=%0d, want ovf=0 dc=0 v=1 d=40",
               overflow, drop_cnt, m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int b = 0; b < 32; b++) tick();
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_reset_midstream();
    m_ready = 1'b1;
    x = mk_x(70); x_label = mk_l(4); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    n_tests++;
    if ({m_valid, m_index, m_data} !== {1'b1, 4'd7, 8'd77}) begin
      n_fail++;
      $display("FAIL midrst_beat7: got v=%b i=%0d d=%0d, want v=1 i=7 d=77",
               m_valid, m_index, m_data);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({m_valid, m_index, m_data} !== {1'b0, 4'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b i=%0d d=%0d, want v=0 i=0 d=0",
               m_valid, m_index, m_data);
    end
    tick();
    rst = 1'b1;
    tick();
    x = mk_x(120); x_label = mk_l(8); x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if ({m_valid, m_data, m_label, m_index} !== {1'b1, 8'(120 + k), 4'(8 + k), 4'(k)}) begin
        n_fail++;
        $display("FAIL midrst_next_beat%0d: got v=%b d=%0d l=%0d i=%0d, want v=1 d=%0d l=%0d i=%0d",
                 k, m_valid, m_data, m_label, m_index, 120 + k, (8 + k) % 16, k);
      end
      tick();
    end
    n_tests++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_done: m_valid got %b want 0", m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_reuse_freed_slot();
    test_drop_saturate();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
